// File: rtl/shadow_stack_ctrl_if.sv
// Shadow-stack memory port between the shadow stack controller and the load/store unit.
// The controller issues req/we/addr/wdata; the LSU answers with gnt, rvalid and rdata.
interface shadow_stack_ctrl_if #(
  parameter int XLEN = 64
);
  logic            mem_req_o;
  logic            mem_gnt_i;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/shadow_stack_ctrl.sv
// Shadow stack pointer owner: sequences SSPUSH/SSPOPCHK/SSPINC/SSPRR at commit and CSR writes of SSP,
// performing the shadow-stack store or load-and-compare through a req/gnt/rvalid LSU port.
module shadow_stack_ctrl #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] SSP_RESET = {XLEN{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              xBCFIE_i,
  input  logic              flush_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [1:0]        op_type_i,
  input  logic [XLEN-1:0]   op_data_i,
  input  logic [XLEN-1:0]   op_imm_i,
  output logic              done_o,
  output logic              fault_o,
  output logic [XLEN-1:0]   result_o,
  input  logic              csr_we_i,
  input  logic [XLEN-1:0]   csr_wdata_i,
  output logic [XLEN-1:0]   ssp_o,
  shadow_stack_ctrl_if.master mem
);

  localparam logic [1:0] OP_PUSH   = 2'd0;
  localparam logic [1:0] OP_POPCHK = 2'd1;
  localparam logic [1:0] OP_INC    = 2'd2;
  localparam logic [1:0] OP_RR     = 2'd3;

  localparam int unsigned     STEP_SHIFT = $clog2(XLEN / 8);
  localparam logic [XLEN-1:0] STEP       = XLEN'(XLEN / 8);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_REQ = 3'd1,
    ST_POP_REQ  = 3'd2,
    ST_POP_WAIT = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [XLEN-1:0] ssp_r, ssp_s;
  logic [XLEN-1:0] data_r, data_s;
  logic            done_r, done_s;
  logic            fault_r, fault_s;
  logic [XLEN-1:0] result_r, result_s;
  logic            mem_req_r, mem_req_s;
  logic            mem_we_r, mem_we_s;
  logic [XLEN-1:0] mem_addr_r, mem_addr_s;
  logic [XLEN-1:0] mem_wdata_r, mem_wdata_s;
  logic            op_ready_s;
  logic            op_accept_s;

  assign op_ready_s  = (state_r == ST_IDLE) & ~csr_we_i & ~flush_i;
  assign op_accept_s = op_valid_i & op_ready_s;

  assign op_ready_o      = op_ready_s;
  assign done_o          = done_r;
  assign fault_o         = fault_r;
  assign result_o        = result_r;
  assign ssp_o           = ssp_r;
  assign mem.mem_req_o   = mem_req_r;
  assign mem.mem_we_o    = mem_we_r;
  assign mem.mem_addr_o  = mem_addr_r;
  assign mem.mem_wdata_o = mem_wdata_r;

  // Next-state, SSP update, completion and memory-request computation.
  always_comb begin
    state_s  = state_r;
    ssp_s    = ssp_r;
    data_s   = data_r;
    done_s   = 1'b0;
    fault_s  = 1'b0;
    result_s = {XLEN{1'b0}};

    case (state_r)
      ST_IDLE: begin
        if (csr_we_i) begin
          ssp_s = csr_wdata_i;
        end else if (op_accept_s) begin
          if (!xBCFIE_i) begin
            done_s = 1'b1;
          end else begin
            case (op_type_i)
              OP_PUSH: begin
                data_s  = op_data_i;
                state_s = ST_PUSH_REQ;
              end
              OP_POPCHK: begin
                data_s  = op_data_i;
                state_s = ST_POP_REQ;
              end
              OP_INC: begin
                ssp_s  = ssp_r + (op_imm_i << STEP_SHIFT);
                done_s = 1'b1;
              end
              OP_RR: begin
                result_s = ssp_r;
                done_s   = 1'b1;
              end
              default: begin
                state_s = ST_IDLE;
              end
            endcase
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      // A grant in the same cycle as a flush still completes the op.
      ST_PUSH_REQ: begin
        if (mem.mem_gnt_i) begin
          ssp_s   = ssp_r - STEP;
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (flush_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_PUSH_REQ;
        end
      end

      ST_POP_REQ: begin
        if (mem.mem_gnt_i) begin
          state_s = ST_POP_WAIT;
        end else if (flush_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_POP_REQ;
        end
      end

      // Flush coinciding with rvalid consumes that response, so no drain is needed.
      ST_POP_WAIT: begin
        if (flush_i) begin
          state_s = mem.mem_rvalid_i ? ST_IDLE : ST_DRAIN;
        end else if (mem.mem_rvalid_i) begin
          result_s = mem.mem_rdata_i;
          done_s   = 1'b1;
          state_s  = ST_IDLE;
          if (mem.mem_rdata_i == data_r) begin
            ssp_s = ssp_r + STEP;
          end else begin
            fault_s = 1'b1;
          end
        end else begin
          state_s = ST_POP_WAIT;
        end
      end

      ST_DRAIN: begin
        if (mem.mem_rvalid_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {XLEN{1'b0}};
    mem_wdata_s = {XLEN{1'b0}};
    // SSP cannot change while a request is pending, so request fields stay stable until gnt.
    case (state_s)
      ST_PUSH_REQ: begin
        mem_req_s   = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = ssp_r - STEP;
        mem_wdata_s = data_s;
      end
      ST_POP_REQ: begin
        mem_req_s  = 1'b1;
        mem_addr_s = ssp_r;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State, SSP and registered output update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      ssp_r       <= SSP_RESET;
      data_r      <= {XLEN{1'b0}};
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {XLEN{1'b0}};
      mem_wdata_r <= {XLEN{1'b0}};
    end else begin
      state_r     <= state_s;
      ssp_r       <= ssp_s;
      data_r      <= data_s;
      done_r      <= done_s;
      fault_r     <= fault_s;
      result_r    <= result_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_shadow_stack_ctrl.sv
// Self-checking bench for shadow_stack_ctrl: directed sequences, a vector table and randomized
// single-op transactions checked against a transaction-level SSP model.
module tb_shadow_stack_ctrl;

  localparam logic [1:0] OP_PUSH   = 2'd0;
  localparam logic [1:0] OP_POPCHK = 2'd1;
  localparam logic [1:0] OP_INC    = 2'd2;
  localparam logic [1:0] OP_RR     = 2'd3;
  localparam logic [63:0] SSP_RST  = 64'h1000;

  logic        clk;
  logic        rst_n;
  logic        xbcfie;
  logic        flush;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_type;
  logic [63:0] op_data;
  logic [63:0] op_imm;
  logic        done;
  logic        fault;
  logic [63:0] result;
  logic        csr_we;
  logic [63:0] csr_wdata;
  logic [63:0] ssp;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] m_ssp;

  shadow_stack_ctrl_if #(.XLEN(64)) mem_if ();

  shadow_stack_ctrl #(.XLEN(64), .SSP_RESET(SSP_RST)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .xBCFIE_i    (xbcfie),
    .flush_i     (flush),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .op_type_i   (op_type),
    .op_data_i   (op_data),
    .op_imm_i    (op_imm),
    .done_o      (done),
    .fault_o     (fault),
    .result_o    (result),
    .csr_we_i    (csr_we),
    .csr_wdata_i (csr_wdata),
    .ssp_o       (ssp),
    .mem         (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic en, input logic [1:0] typ, input logic [63:0] data, input logic [63:0] imm);
    xbcfie   = en;
    op_type  = typ;
    op_data  = data;
    op_imm   = imm;
    op_valid = 1'b1;
    #1;
    chk("op_ready_idle", {63'd0, op_ready}, 64'd1);
    tick();
    op_valid = 1'b0;
  endtask

  typedef struct {
    logic        csr_we;
    logic [63:0] csr_wdata;
    logic        en;
    logic [1:0]  typ;
    logic [63:0] imm;
    logic        exp_ready;
    logic        exp_done;
    logic [63:0] exp_result;
    logic [63:0] exp_ssp;
  } vec_t;

  vec_t vecs[13];

  task automatic rand_op();
    int kind;
    logic        en;
    logic [1:0]  typ;
    logic [63:0] data, imm, rd, wd;
    int mode;
    kind = $urandom_range(0, 9);
    if (kind == 0) begin
      wd        = {$urandom, $urandom} & ~64'h7;
      csr_we    = 1'b1;
      csr_wdata = wd;
      op_valid  = 1'($urandom_range(0, 1));
      op_type   = 2'($urandom_range(0, 3));
      #1;
      chk("r_csr_ready", {63'd0, op_ready}, 64'd0);
      tick();
      csr_we   = 1'b0;
      op_valid = 1'b0;
      m_ssp    = wd;
      chk("r_csr_ssp", ssp, m_ssp);
      chk("r_csr_done", {63'd0, done}, 64'd0);
    end else if (kind == 1) begin
      op_valid = 1'b1;
      flush    = 1'b1;
      #1;
      chk("r_flush_ready", {63'd0, op_ready}, 64'd0);
      tick();
      op_valid = 1'b0;
      flush    = 1'b0;
      chk("r_flush_done", {63'd0, done}, 64'd0);
      chk("r_flush_ssp", ssp, m_ssp);
    end else begin
      en   = ($urandom_range(0, 3) != 0);
      typ  = 2'($urandom_range(0, 3));
      data = {$urandom, $urandom};
      imm  = ($urandom_range(0, 4) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 8));
      issue(en, typ, data, imm);
      if (!en || typ == OP_RR || typ == OP_INC) begin
        if (en && typ == OP_INC) m_ssp = m_ssp + imm * 64'd8;
        chk("r_simple_done", {63'd0, done}, 64'd1);
        chk("r_simple_fault", {63'd0, fault}, 64'd0);
        chk("r_simple_result", result, (en && typ == OP_RR) ? ssp_before(imm, typ, en) : 64'd0);
        chk("r_simple_ssp", ssp, m_ssp);
        chk("r_simple_noreq", {63'd0, mem_if.mem_req_o}, 64'd0);
      end else begin
        for (int i = 0; i < $urandom_range(0, 3); i++) begin
          chk("r_req_hold", {63'd0, mem_if.mem_req_o}, 64'd1);
          tick();
        end
        chk("r_req", {63'd0, mem_if.mem_req_o}, 64'd1);
        chk("r_req_we", {63'd0, mem_if.mem_we_o}, (typ == OP_PUSH) ? 64'd1 : 64'd0);
        chk("r_req_addr", mem_if.mem_addr_o, (typ == OP_PUSH) ? m_ssp - 64'd8 : m_ssp);
        if (typ == OP_PUSH) chk("r_req_wdata", mem_if.mem_wdata_o, data);
        mode = $urandom_range(0, 5);
        if (mode == 0) begin
          flush = 1'b1;
          tick();
          flush = 1'b0;
          chk("r_abort_req", {63'd0, mem_if.mem_req_o}, 64'd0);
          chk("r_abort_done", {63'd0, done}, 64'd0);
          chk("r_abort_ssp", ssp, m_ssp);
        end else begin
          mem_if.mem_gnt_i = 1'b1;
          flush = (mode == 1);
          tick();
          mem_if.mem_gnt_i = 1'b0;
          flush = 1'b0;
          chk("r_gnt_req", {63'd0, mem_if.mem_req_o}, 64'd0);
          if (typ == OP_PUSH) begin
            m_ssp = m_ssp - 64'd8;
            chk("r_push_done", {63'd0, done}, 64'd1);
            chk("r_push_fault", {63'd0, fault}, 64'd0);
            chk("r_push_ssp", ssp, m_ssp);
          end else begin
            chk("r_pop_gnt_done", {63'd0, done}, 64'd0);
            for (int i = 0; i < $urandom_range(0, 3); i++) tick();
            if ($urandom_range(0, 4) == 0) begin
              flush = 1'b1;
              tick();
              flush = 1'b0;
              for (int i = 0; i < $urandom_range(0, 3); i++) begin
                chk("r_drain_ready", {63'd0, op_ready}, 64'd0);
                tick();
              end
              mem_if.mem_rvalid_i = 1'b1;
              mem_if.mem_rdata_i  = data;
              tick();
              mem_if.mem_rvalid_i = 1'b0;
              chk("r_drain_done", {63'd0, done}, 64'd0);
              chk("r_drain_ssp", ssp, m_ssp);
            end else begin
              rd = ($urandom_range(0, 1) == 0) ? data : {$urandom, $urandom};
              mem_if.mem_rvalid_i = 1'b1;
              mem_if.mem_rdata_i  = rd;
              tick();
              mem_if.mem_rvalid_i = 1'b0;
              if (rd == data) m_ssp = m_ssp + 64'd8;
              chk("r_pop_done", {63'd0, done}, 64'd1);
              chk("r_pop_result", result, rd);
              chk("r_pop_fault", {63'd0, fault}, (rd == data) ? 64'd0 : 64'd1);
              chk("r_pop_ssp", ssp, m_ssp);
            end
          end
        end
      end
    end
  endtask

  // SSPRR reports the SSP held before the op; RR never changes the model SSP.
  function automatic logic [63:0] ssp_before(input logic [63:0] imm, input logic [1:0] typ, input logic en);
    return (en && typ == OP_INC) ? m_ssp - imm * 64'd8 : m_ssp;
  endfunction

  initial begin
    rst_n = 1'b0; xbcfie = 1'b1; flush = 1'b0; op_valid = 1'b0; op_type = 2'd0;
    op_data = 64'd0; op_imm = 64'd0; csr_we = 1'b0; csr_wdata = 64'd0;
    mem_if.mem_gnt_i = 1'b0; mem_if.mem_rvalid_i = 1'b0; mem_if.mem_rdata_i = 64'd0;
    tick(); tick();
    chk("rst_ssp", ssp, SSP_RST);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_req", {63'd0, mem_if.mem_req_o}, 64'd0);
    chk("rst_addr", mem_if.mem_addr_o, 64'd0);
    rst_n = 1'b1;
    tick();

    // SSPUSH with grant after two wait cycles.
    issue(1'b1, OP_PUSH, 64'hDEAD_BEEF, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("push_req", {63'd0, mem_if.mem_req_o}, 64'd1);
      chk("push_we", {63'd0, mem_if.mem_we_o}, 64'd1);
      chk("push_addr", mem_if.mem_addr_o, 64'hFF8);
      chk("push_wdata", mem_if.mem_wdata_o, 64'hDEAD_BEEF);
      chk("push_busy_ready", {63'd0, op_ready}, 64'd0);
      if (i == 2) mem_if.mem_gnt_i = 1'b1;
      tick();
    end
    mem_if.mem_gnt_i = 1'b0;
    chk("push_req_off", {63'd0, mem_if.mem_req_o}, 64'd0);
    chk("push_done", {63'd0, done}, 64'd1);
    chk("push_fault", {63'd0, fault}, 64'd0);
    chk("push_ssp", ssp, 64'hFF8);
    tick();
    chk("push_done_pulse", {63'd0, done}, 64'd0);

    // SSPOPCHK match, then mismatch from the same SSP.
    for (int k = 0; k < 2; k++) begin
      issue(1'b1, OP_POPCHK, (k == 0) ? 64'hDEAD_BEEF : 64'h1234, 64'd0);
      chk("pop_req", {63'd0, mem_if.mem_req_o}, 64'd1);
      chk("pop_we", {63'd0, mem_if.mem_we_o}, 64'd0);
      chk("pop_addr", mem_if.mem_addr_o, 64'hFF8);
      mem_if.mem_gnt_i = 1'b1;
      tick();
      mem_if.mem_gnt_i = 1'b0;
      chk("pop_wait_done", {63'd0, done}, 64'd0);
      tick();
      mem_if.mem_rvalid_i = 1'b1;
      mem_if.mem_rdata_i  = 64'hDEAD_BEEF;
      tick();
      mem_if.mem_rvalid_i = 1'b0;
      chk("pop_done", {63'd0, done}, 64'd1);
      chk("pop_result", result, 64'hDEAD_BEEF);
      chk("pop_fault", {63'd0, fault}, (k == 0) ? 64'd0 : 64'd1);
      chk("pop_ssp", ssp, (k == 0) ? 64'h1000 : 64'hFF8);
      if (k == 0) begin
        csr_we = 1'b1; csr_wdata = 64'hFF8;
        tick();
        csr_we = 1'b0;
      end
    end

    vecs[0]  = '{1'b1, 64'h1000, 1'b1, OP_RR, 64'd0, 1'b0, 1'b0, 64'd0, 64'h1000};
    vecs[1]  = '{1'b0, 64'd0, 1'b1, OP_INC, 64'd3, 1'b1, 1'b1, 64'd0, 64'h1018};
    vecs[2]  = '{1'b0, 64'd0, 1'b1, OP_RR, 64'd0, 1'b1, 1'b1, 64'h1018, 64'h1018};
    vecs[3]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, OP_INC, 64'd1, 1'b0, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[4]  = '{1'b0, 64'd0, 1'b1, OP_INC, 64'd1, 1'b1, 1'b1, 64'd0, 64'd0};
    vecs[5]  = '{1'b0, 64'd0, 1'b0, OP_PUSH, 64'd0, 1'b1, 1'b1, 64'd0, 64'd0};
    vecs[6]  = '{1'b0, 64'd0, 1'b0, OP_POPCHK, 64'd0, 1'b1, 1'b1, 64'd0, 64'd0};
    vecs[7]  = '{1'b0, 64'd0, 1'b0, OP_RR, 64'd0, 1'b1, 1'b1, 64'd0, 64'd0};
    vecs[8]  = '{1'b0, 64'd0, 1'b0, OP_INC, 64'd5, 1'b1, 1'b1, 64'd0, 64'd0};
    vecs[9]  = '{1'b1, 64'h2000, 1'b1, OP_RR, 64'd0, 1'b0, 1'b0, 64'd0, 64'h2000};
    vecs[10] = '{1'b0, 64'd0, 1'b1, OP_RR, 64'd0, 1'b1, 1'b1, 64'h2000, 64'h2000};
    vecs[11] = '{1'b0, 64'd0, 1'b1, OP_INC, 64'd0, 1'b1, 1'b1, 64'd0, 64'h2000};
    vecs[12] = '{1'b0, 64'd0, 1'b0, OP_RR, 64'd0, 1'b1, 1'b1, 64'd0, 64'h2000};
    for (int v = 0; v < 13; v++) begin
      csr_we = vecs[v].csr_we; csr_wdata = vecs[v].csr_wdata;
      xbcfie = vecs[v].en; op_type = vecs[v].typ; op_imm = vecs[v].imm;
      op_data = 64'h5555; op_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d_ready", v), {63'd0, op_ready}, {63'd0, vecs[v].exp_ready});
      tick();
      chk($sformatf("vec%0d_done", v), {63'd0, done}, {63'd0, vecs[v].exp_done});
      if (vecs[v].exp_done) chk($sformatf("vec%0d_result", v), result, vecs[v].exp_result);
      chk($sformatf("vec%0d_fault", v), {63'd0, fault}, 64'd0);
      chk($sformatf("vec%0d_ssp", v), ssp, vecs[v].exp_ssp);
      chk($sformatf("vec%0d_noreq", v), {63'd0, mem_if.mem_req_o}, 64'd0);
    end
    op_valid = 1'b0; csr_we = 1'b0; xbcfie = 1'b1;
    tick();

    // Flush in POP_REQ without grant.
    issue(1'b1, OP_POPCHK, 64'h77, 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_req_req", {63'd0, mem_if.mem_req_o}, 64'd0);
    chk("fl_req_done", {63'd0, done}, 64'd0);
    tick();
    chk("fl_req_done2", {63'd0, done}, 64'd0);
    chk("fl_req_ready", {63'd0, op_ready}, 64'd1);
    chk("fl_req_ssp", ssp, 64'h2000);

    // Flush in POP_WAIT drains the late response.
    issue(1'b1, OP_POPCHK, 64'h77, 64'd0);
    mem_if.mem_gnt_i = 1'b1;
    tick();
    mem_if.mem_gnt_i = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("fl_drain_ready", {63'd0, op_ready}, 64'd0);
    mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 64'h77;
    tick();
    mem_if.mem_rvalid_i = 1'b0;
    chk("fl_drain_done", {63'd0, done}, 64'd0);
    chk("fl_drain_ssp", ssp, 64'h2000);
    chk("fl_drain_ready2", {63'd0, op_ready}, 64'd1);

    // Asynchronous reset while in PUSH_REQ.
    issue(1'b1, OP_PUSH, 64'hABCD, 64'd0);
    chk("ar_req_before", {63'd0, mem_if.mem_req_o}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", {63'd0, mem_if.mem_req_o}, 64'd0);
    chk("ar_ssp", ssp, SSP_RST);
    chk("ar_wdata", mem_if.mem_wdata_o, 64'd0);
    tick();
    rst_n = 1'b1;
    mem_if.mem_rvalid_i = 1'b1;
    tick();
    mem_if.mem_rvalid_i = 1'b0;
    chk("ar_rvalid_done", {63'd0, done}, 64'd0);
    chk("ar_rvalid_ssp", ssp, SSP_RST);

    m_ssp = SSP_RST;
    for (int n = 0; n < 400; n++) rand_op();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
